// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and width codes for the load/store unit
// Contents: lsu_state_e (FSM states), LSU_* funct3 width/sign codes.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational store lane/byte-enable and load extract/extend
// Ports:
//   st_size  : mask[1:0] of the request (00 byte, 01 half, 1x word)
//   st_off   : naturally aligned byte offset of the store
//   st_data  : raw store data (rs2)
//   st_be    : byte enables for the bus
//   st_lanes : store data replicated across the byte lanes
//   ld_mask  : funct3 of the outstanding load
//   ld_off   : byte offset of the outstanding load
//   ld_word  : word returned by the bus
//   ld_data  : extracted and extended load result
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_lanes,
   input  logic [2:0]  ld_mask,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   // Size is taken from the low two bits so loads (incl. unsigned codes)
   // get the same byte enables as stores of the same width.
   always_comb begin
      st_be    = 4'b1111;
      st_lanes = st_data;
      case (st_size)
         2'b00: begin
            st_be    = 4'b0001 << st_off;
            st_lanes = {4{st_data[7:0]}};
         end
         2'b01: begin
            st_be    = 4'b0011 << st_off;
            st_lanes = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   assign shifted = ld_word >> {ld_off, 3'b000};

   always_comb begin
      ld_data = shifted;
      case (ld_mask)
         LSU_B:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
         LSU_H:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
         LSU_BU:  ld_data = {24'd0, shifted[7:0]};
         LSU_HU:  ld_data = {16'd0, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory access stage with req/gnt/rvalid handshake
// Optional feature macro: LSU_MISALIGN_ERR_EN (misaligned requests raise err_o
// instead of being forced to natural alignment).
// Ports:
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   req_valid_i/ready_o   : request handshake from execute (ready only in IDLE)
//   mem_rd_i, mem_wr_i    : load / store select
//   mask_i                : funct3 width/sign code
//   addr_i, wdata_i       : byte address, store data
//   dmem_req_o/we_o/addr_o/be_o/wdata_o : registered bus request fields
//   dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i : bus grant and read response
//   done_o                : one-cycle completion pulse
//   rdata_o               : extended load result, held until the next load
//   err_o                 : one-cycle pulse for a rejected request
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              mem_rd_i,
   input  logic              mem_wr_i,
   input  logic [2:0]        mask_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [ADDR_W-1:0] dmem_addr_o,
   output logic [3:0]        dmem_be_o,
   output logic [31:0]       dmem_wdata_o,
   input  logic              dmem_gnt_i,
   input  logic              dmem_rvalid_i,
   input  logic [31:0]       dmem_rdata_i,
   output logic              done_o,
   output logic [31:0]       rdata_o,
   output logic              err_o
);

   lsu_state_e  state_q, state_d;
   logic        is_ld, is_st, op_ok, legal;
   logic [1:0]  off, off_eff;
   logic [2:0]  mask_q;
   logic [1:0]  off_q;
   logic [3:0]  be_c;
   logic [31:0] lanes_c, ld_fmt;

   assign off = addr_i[1:0];

   always_comb begin
      is_ld   = mem_rd_i & ~mem_wr_i;
      is_st   = mem_wr_i & ~mem_rd_i;
      op_ok   = 1'b0;
      if (is_ld)
         op_ok = mask_i inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU};
      else if (is_st)
         op_ok = mask_i inside {LSU_B, LSU_H, LSU_W};

      // Natural alignment of the offset; a request is aligned exactly when
      // this leaves the offset unchanged.
      off_eff = off;
      case (mask_i)
         LSU_H, LSU_HU: off_eff = {off[1], 1'b0};
         LSU_W:         off_eff = 2'b00;
         default:       ;
      endcase

`ifdef LSU_MISALIGN_ERR_EN
      legal = op_ok & (off_eff == off);
`else
      legal = op_ok;
`endif
   end

   lsu_align u_align (
      .st_size  (mask_i[1:0]),
      .st_off   (off_eff),
      .st_data  (wdata_i),
      .st_be    (be_c),
      .st_lanes (lanes_c),
      .ld_mask  (mask_q),
      .ld_off   (off_q),
      .ld_word  (dmem_rdata_i),
      .ld_data  (ld_fmt)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req_valid_i && legal) state_d = ST_REQ;
         ST_REQ:  if (dmem_gnt_i) state_d = dmem_we_o ? ST_DONE : ST_WAIT;
         ST_WAIT: if (dmem_rvalid_i) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign req_ready_o = (state_q == ST_IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         dmem_req_o   <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_addr_o  <= '0;
         dmem_be_o    <= 4'd0;
         dmem_wdata_o <= 32'd0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
         rdata_o      <= 32'd0;
         mask_q       <= 3'd0;
         off_q        <= 2'd0;
      end else begin
         state_q <= state_d;
         done_o  <= 1'b0;
         err_o   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i) begin
                  if (legal) begin
                     dmem_req_o   <= 1'b1;
                     dmem_we_o    <= is_st;
                     dmem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                     dmem_be_o    <= be_c;
                     dmem_wdata_o <= lanes_c;
                     mask_q       <= mask_i;
                     off_q        <= off_eff;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               // Fields stay frozen until the grant; rvalid is not looked at here.
               if (dmem_gnt_i) begin
                  dmem_req_o <= 1'b0;
                  if (dmem_we_o) done_o <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (dmem_rvalid_i) begin
                  rdata_o <= ld_fmt;
                  done_o  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with random stimulus
module tb_load_store_unit;

   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              mem_rd, mem_wr;
   logic [2:0]        mask;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              dmem_req, dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [3:0]        dmem_be;
   logic [31:0]       dmem_wdata;
   logic              gnt, rvalid;
   logic [31:0]       rdata_in;
   logic              done, err;
   logic [31:0]       rdata;

   load_store_unit #(.ADDR_W(ADDR_W)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .mem_rd_i     (mem_rd),
      .mem_wr_i     (mem_wr),
      .mask_i       (mask),
      .addr_i       (addr),
      .wdata_i      (wdata),
      .dmem_req_o   (dmem_req),
      .dmem_we_o    (dmem_we),
      .dmem_addr_o  (dmem_addr),
      .dmem_be_o    (dmem_be),
      .dmem_wdata_o (dmem_wdata),
      .dmem_gnt_i   (gnt),
      .dmem_rvalid_i(rvalid),
      .dmem_rdata_i (rdata_in),
      .done_o       (done),
      .rdata_o      (rdata),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_err;
      int          cyc;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      int          gd;
      int          rd;
      logic [31:0] word;
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   exp_t        sbq[$];
   bus_t        busq[$];
   logic [31:0] last_load = 32'd0;
   bit          resp_en = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: everything computed from byte sizes and offsets.
   task automatic issue(input bit rd, input bit wr, input logic [2:0] m, input logic [31:0] a,
                        input logic [31:0] wd, input int gd, input int rdl, input logic [31:0] word);
      exp_t  e;
      bus_t  b;
      int    n, sz, off;
      bit    ok, ld, st;
      longint val;
      @(negedge clk);
      n = 0;
      while (!req_ready) begin
         @(negedge clk);
         n++;
         if (n > 200) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 200 cycles");
            return;
         end
      end
      ld  = rd && !wr;
      st  = wr && !rd;
      sz  = (m[1:0] == 2'b00) ? 1 : (m[1:0] == 2'b01) ? 2 : 4;
      ok  = (ld && (m inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
            (st && (m inside {3'b000, 3'b001, 3'b010}));
      off = int'(a % 4);
`ifdef LSU_MISALIGN_ERR_EN
      if ((off % sz) != 0) ok = 1'b0;
`endif
      off = off - (off % sz);
      e.is_err = !ok;
      if (!ok) begin
         e.cyc = cyc + 1;
      end else begin
         b.gd = gd; b.rd = rdl; b.word = word; b.we = st;
         b.addr = a & 32'hFFFF_FFFC;
         b.be = 4'(((1 << sz) - 1) << off);
         b.wdata = 32'd0;
         for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
         busq.push_back(b);
         if (st) begin
            e.cyc = cyc + 2 + gd;
         end else begin
            e.cyc = cyc + 3 + gd + rdl;
            val = 0;
            for (int k = 0; k < sz; k++) val = val + (longint'(word[8*(off+k) +: 8]) << (8*k));
            if (!m[2] && sz < 4 && val >= (longint'(1) << (8*sz - 1))) val = val - (longint'(1) << (8*sz));
            last_load = val[31:0];
         end
      end
      e.rdata = last_load;
      sbq.push_back(e);
      mem_rd = rd; mem_wr = wr; mask = m; addr = a; wdata = wd;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      mem_rd = $urandom % 2; mem_wr = $urandom % 2; mask = 3'($urandom); addr = $urandom; wdata = $urandom;
   endtask

   // Bus responder: checks request fields, applies chosen grant/rvalid delays.
   initial begin : responder
      bus_t        b;
      logic [31:0] wd0;
      gnt = 1'b0; rvalid = 1'b0; rdata_in = 32'd0;
      forever begin
         @(negedge clk);
         if (resp_en && rst_n && dmem_req) begin
            if (busq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_bus_req: got dmem_req=1 expected 0");
               @(posedge clk);
            end else begin
               b = busq.pop_front();
               wd0 = dmem_wdata;
               check("bus_we", dmem_we, b.we);
               check("bus_addr", dmem_addr, b.addr);
               check("bus_be", dmem_be, b.be);
               if (b.we) check("bus_wdata", dmem_wdata, b.wdata);
               for (int i = 0; i < b.gd; i++) begin
                  rvalid = $urandom % 2; rdata_in = $urandom;
                  @(negedge clk);
                  check("hold_req", dmem_req, 1'b1);
                  check("hold_addr", dmem_addr, b.addr);
                  check("hold_be", dmem_be, b.be);
                  check("hold_wdata", dmem_wdata, wd0);
               end
               rvalid = 1'b0;
               gnt = 1'b1;
               @(posedge clk);
               #1 gnt = 1'b0;
               if (!b.we) begin
                  @(negedge clk);
                  for (int i = 0; i < b.rd; i++) begin
                     rdata_in = $urandom;
                     @(negedge clk);
                  end
                  rvalid = 1'b1; rdata_in = b.word;
                  @(posedge clk);
                  #1 rvalid = 1'b0; rdata_in = $urandom;
               end
            end
         end else if (resp_en) begin
            rvalid = ($urandom % 4) == 0;
            rdata_in = $urandom;
         end
      end
   end

   // Monitor: pops the scoreboard on every completion or error pulse.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         if (dmem_req) check("ready_low_in_access", req_ready, 1'b0);
         if (done || err) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_completion: got done=%0b err=%0b expected none", done, err);
            end else begin
               e = sbq.pop_front();
               check("err_pulse", err, e.is_err);
               check("done_pulse", done, !e.is_err);
               check("completion_cycle", cyc, e.cyc);
               check("rdata", rdata, e.rdata);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int r, n, dn;
      logic [2:0] m;
      logic [2:0] legal_m [5];
      legal_m[0] = 3'b000; legal_m[1] = 3'b001; legal_m[2] = 3'b010;
      legal_m[3] = 3'b100; legal_m[4] = 3'b101;
      rst_n = 1'b0; req_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      mask = 3'd0; addr = '0; wdata = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_ready", req_ready, 1'b1);
      check("rst_req", dmem_req, 1'b0);
      check("rst_we", dmem_we, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_be", dmem_be, 4'd0);
      check("rst_wdata", dmem_wdata, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      rst_n = 1'b1;

      issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'd0);
      issue(0, 1, 3'b000, 32'h103, 32'h000000A5, 1, 0, 32'd0);
      issue(1, 0, 3'b000, 32'h102, 32'd0, 0, 0, 32'h0080_0000);
      issue(1, 0, 3'b100, 32'h102, 32'd0, 0, 1, 32'h0080_0000);
      issue(1, 0, 3'b101, 32'h102, 32'd0, 2, 0, 32'h8001_0000);
      issue(1, 0, 3'b010, 32'h104, 32'd0, 3, 2, 32'h1357_9BDF);
      issue(1, 0, 3'b001, 32'h101, 32'd0, 0, 0, 32'h1234_ABCD);
      issue(0, 1, 3'b001, 32'h10E, 32'h0000_BEEF, 1, 0, 32'd0);
      issue(1, 1, 3'b010, 32'h100, 32'd0, 0, 0, 32'd0);
      issue(0, 0, 3'b010, 32'h100, 32'd0, 0, 0, 32'd0);
      issue(0, 1, 3'b100, 32'h100, 32'd0, 0, 0, 32'd0);
      issue(1, 0, 3'b011, 32'h100, 32'd0, 0, 0, 32'd0);

      for (int t = 0; t < 150; t++) begin
         r = $urandom % 8;
         m = ($urandom % 4 != 0) ? legal_m[$urandom % 5] : 3'($urandom);
         issue(r == 0 || r >= 5, r >= 2 && r <= 4 || r == 0, m, 32'h100 + ($urandom % 64),
               $urandom, $urandom % 4, $urandom % 3, $urandom);
      end

      n = 0;
      while ((sbq.size() != 0 || busq.size() != 0 || !req_ready) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", (n < 1000) ? 32'd1 : 32'd0, 32'd1);

      // Reset while in REQ, then while in WAIT.
      resp_en = 1'b0; gnt = 1'b0; rvalid = 1'b0;
      @(negedge clk);
      mem_rd = 1'b1; mem_wr = 1'b0; mask = 3'b010; addr = 32'h108; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("abort_req_high", dmem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_req_drop", dmem_req, 1'b0);
      check("abort_req_ready", req_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_rd = 1'b1; mem_wr = 1'b0; mask = 3'b010; addr = 32'h10C; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      gnt = 1'b1;
      @(posedge clk);
      #1 gnt = 1'b0;
      @(negedge clk);
      check("wait_ready_low", req_ready, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("wait_abort_ready", req_ready, 1'b1);
      check("wait_abort_req", dmem_req, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      rvalid = 1'b1; rdata_in = 32'hCAFE_F00D;
      @(posedge clk);
      #1 rvalid = 1'b0;
      dn = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("late_rvalid_no_done", dn, 32'd0);
      check("late_rvalid_rdata", rdata, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage fed by the main control decoder's memory controls (`mem_rd`, `mem_wr`, `mask` = funct3) and the ALU address result. It aligns and byte-enables stores, extracts and sign/zero-extends loads, and runs a req/gnt/rvalid handshake to the data memory. It handles one access at a time and back-pressures the pipeline while an access is outstanding.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `req_valid_i`, in, 1: access request from the execute stage.
- `req_ready_o`, out, 1: LSU can accept a request (high only in IDLE).
- `mem_rd_i`, in, 1: load.
- `mem_wr_i`, in, 1: store.
- `mask_i`, in, 3: funct3 width/sign code.
- `addr_i`, in, ADDR_W: byte address.
- `wdata_i`, in, 32: store data (rs2).
- `dmem_req_o`, out, 1: bus request.
- `dmem_we_o`, out, 1: bus write.
- `dmem_addr_o`, out, ADDR_W: word-aligned address, low 2 bits are 0.
- `dmem_be_o`, out, 4: byte enables.
- `dmem_wdata_o`, out, 32: lane-replicated write data.
- `dmem_gnt_i`, in, 1: bus grant.
- `dmem_rvalid_i`, in, 1: read data valid.
- `dmem_rdata_i`, in, 32: read word.
- `done_o`, out, 1: one-cycle completion pulse for loads and stores.
- `rdata_o`, out, 32: extended load result, held until the next load completes.
- `err_o`, out, 1: one-cycle pulse for an illegal or misaligned request; no bus access is made.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - On `req_valid_i` with a legal request: register address, byte enables, write data, type and offset, then go to REQ.
  - On an illegal request: pulse `err_o` next cycle and stay in IDLE.
- **REQ**
  - `dmem_req_o` = 1, with all `dmem_*` fields held stable until `dmem_gnt_i`.
  - On grant: a store goes to DONE; a load goes to WAIT.
  - `dmem_rvalid_i` is ignored in REQ.
- **WAIT**
  - On `dmem_rvalid_i`: format `dmem_rdata_i`, load it into `rdata_o`, go to DONE.
- **DONE**
  - `done_o` = 1 for one cycle, then IDLE.
- Illegal requests:
  - `mem_rd_i` and `mem_wr_i` both high.
  - Load `mask_i` not in {000, 001, 010, 100, 101}.
  - Store `mask_i` not in {000, 001, 010}.
  - `req_valid_i` with neither `mem_rd_i` nor `mem_wr_i`.
- Byte enables, with `off` = `addr_i[1:0]`:
  - Byte: `4'b0001 << off`.
  - Half: `4'b0011 << off`.
  - Word: `4'b1111`.
- Store data lanes:
  - Byte: 4 copies of `wdata_i[7:0]`.
  - Half: 2 copies of `wdata_i[15:0]`.
  - Word: unchanged.
- Load format: shift `dmem_rdata_i` right by 8·`off`, then:
  - 000 (LB): sign-extend bit 7.
  - 001 (LH): sign-extend bit 15.
  - 100 (LBU) / 101 (LHU): zero-extend.
  - 010 (LW): pass the word through.
- Misaligned: a half access with `off[0]` = 1, or a word access with `off` ≠ 0 (see Configuration).

## Timing
- Reset values:
  - state IDLE.
  - `req_ready_o` = 1.
  - `dmem_req_o`, `dmem_we_o`, `done_o`, `err_o` = 0.
  - `dmem_addr_o`, `dmem_be_o`, `dmem_wdata_o`, `rdata_o` = 0.
- All `dmem_*`, `done_o`, `rdata_o` and `err_o` are registered. `req_ready_o` is decoded from state.
- Request accepted at edge T; `dmem_req_o` is high from T+1.
- Store with grant at T+1: `done_o` at T+2.
- Load with grant at T+1 and `rvalid` at T+2: `done_o` and the new `rdata_o` at T+3.
- Each extra grant or rvalid wait cycle adds one cycle.
- Illegal request accepted at T: `err_o` at T+1, `req_ready_o` stays 1.
- Reset mid-access: `dmem_req_o` drops asynchronously and the outstanding access is abandoned. A late `dmem_rvalid_i` seen in IDLE is ignored.
- `req_valid_i` outside IDLE is ignored; the upstream stage holds it.

## Configuration
- `LSU_MISALIGN_ERR_EN` defined: a misaligned request is illegal, giving an `err_o` pulse and no bus access.
- `LSU_MISALIGN_ERR_EN` undefined: the offset is forced to natural alignment (half: `off[0]` cleared; word: `off` cleared) and the access proceeds.
  - `err_o` then fires only for illegal opcode combinations and funct3 values.

## Structure
- Package `lsu_pkg` holds:
  - the state enum `lsu_state_e`;
  - the width codes `LSU_B` = 3'b000, `LSU_H` = 3'b001, `LSU_W` = 3'b010, `LSU_BU` = 3'b100, `LSU_HU` = 3'b101.
- Sub-module `lsu_align` is purely combinational:
  - store side: byte-enable and lane replication;
  - load side: shift and extend.
- `load_store_unit` holds the FSM and the registers.

## Test plan
- SW to 0x100 with data 0xDEADBEEF, `gnt` same cycle as `dmem_req_o` -> `be`=1111, `addr`=0x100, `wdata`=0xDEADBEEF, `done_o` 2 cycles after accept.
- SB to 0x103 with data 0x000000A5 -> `be`=1000, `wdata`=0xA5A5A5A5, `addr`=0x100.
- LB from 0x102, read data 0x0080_0000 -> `rdata_o`=0xFFFFFF80. LBU from the same -> 0x00000080. LHU from 0x102, read data 0x8001_0000 -> 0x00008001.
- LW with `gnt` delayed 3 cycles and `rvalid` 2 cycles after that -> `dmem_*` fields stable throughout REQ, `req_ready_o`=0 until DONE, a single `done_o` pulse.
- LH from 0x101 -> with `LSU_MISALIGN_ERR_EN`: `err_o` pulse, no `dmem_req_o`. Without it: `addr`=0x100 and the halfword from lanes 1:0 is returned.
- Both `mem_rd_i` and `mem_wr_i` high -> `err_o`. `rst_ni` low during WAIT -> `dmem_req_o`=0 and state IDLE immediately, and a later `rvalid` produces no `done_o`.
